// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first; define UART_TX_PARITY_EN for 8E1 (even parity bit after bit 7).
// Each bit is held DIV = F/BAUD clocks; tx, ready and busy are all registered.
module uart_tx #(
  parameter int F    = 8000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = F / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign bit_end = (baud_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // ready is high exactly while IDLE, so valid alone completes the handshake here
          if (valid) begin
            state    <= START;
            shift    <= data_in;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= ^data_in;
`endif
          end
        end
        default: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + CW'(1);
          end else begin
            baud_cnt <= '0;
            case (state)
              START: begin
                state <= DATA;
                tx    <= shift[0];
              end
              DATA: begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state <= PARITY;
                  tx    <= par;
`else
                  state <= STOP;
                  tx    <= 1'b1;
`endif
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                  shift   <= {1'b0, shift[7:1]};
                  tx      <= shift[1];
                end
              end
`ifdef UART_TX_PARITY_EN
              PARITY: begin
                state <= STOP;
                tx    <= 1'b1;
              end
`endif
              // STOP (and any unreachable encoding) returns to idle
              default: begin
                state <= IDLE;
                tx    <= 1'b1;
                ready <= 1'b1;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
